// File: rtl/addr_bus_responder_pkg.sv
// Shared types and constants for the CPU bus responder.
package addr_bus_responder_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 4;

  // Lowest address of the IO region; everything below is SRAM.
  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 16'hFF00;

  typedef enum logic [1:0] {
    BUSR_IDLE    = 2'b00,
    BUSR_ACCESS  = 2'b01,
    BUSR_ACK     = 2'b10,
    BUSR_RELEASE = 2'b11
  } busr_state_e;

  // Request captured when an access is accepted; held for the whole access.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              is_write;
    logic              is_io;
  } busr_req_t;

  // Region decode: addresses at or above the IO base belong to IO.
  function automatic logic busr_is_io(input logic [ADDR_W-1:0] addr,
                                      input logic [ADDR_W-1:0] io_base);
    return (addr >= io_base);
  endfunction

endpackage

// File: rtl/busr_wait_counter.sv
// Loadable down-counter that times the wait states of one bus access.
module busr_wait_counter
  import addr_bus_responder_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             zero_c
);

  logic [CNT_W-1:0] count_q;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  assign zero_c = (count_q == '0);

endmodule

// File: rtl/addr_bus_responder.sv
// Memory-side bus responder: decodes RAM/IO, inserts wait states, acks once per request.
module addr_bus_responder
  import addr_bus_responder_pkg::*;
#(
  parameter int unsigned       WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE     = IO_BASE_DEFAULT
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [DATA_W-1:0] DATA_IN,
  input  logic              RD,
  input  logic              WR,
  output logic [DATA_W-1:0] DATA_OUT,
  output logic              READY,
  output logic              BUS_ERR,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic              MEM_CE,
  output logic              MEM_WE,
  output logic              IO_SEL,
  output logic              IO_WE,
  input  logic [DATA_W-1:0] IO_RDATA
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_STATES);

  busr_state_e       state_q, state_d;
  busr_req_t         req_q, req_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              ready_q, ready_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_ce_q, mem_ce_d;
  logic              mem_we_q, mem_we_d;
  logic              io_sel_q, io_sel_d;
  logic              io_we_q, io_we_d;
  logic              cnt_load_c;
  logic              cnt_dec_c;
  logic              cnt_zero_c;
  logic              new_io_c;

  busr_wait_counter u_wait_counter (
    .clk      (CLK),
    .rst_n    (RESETN),
    .load     (cnt_load_c),
    .load_val (WAIT_LOAD),
    .dec      (cnt_dec_c),
    .zero_c   (cnt_zero_c)
  );

  assign new_io_c = busr_is_io(ADDR, IO_BASE);

  // Next-state and next-output logic; strobes are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    data_out_d = data_out_q;
    ready_d    = 1'b0;
    bus_err_d  = 1'b0;
    mem_ce_d   = 1'b0;
    mem_we_d   = 1'b0;
    io_sel_d   = 1'b0;
    io_we_d    = 1'b0;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;

    case (state_q)
      BUSR_IDLE: begin
        if (RD && WR) begin
          // Conflicting request: flag it and wait for the requester to let go.
          bus_err_d = 1'b1;
          state_d   = BUSR_RELEASE;
        end else if (RD ^ WR) begin
          req_d.addr     = ADDR;
          req_d.wdata    = DATA_IN;
          req_d.is_write = WR;
          req_d.is_io    = new_io_c;
          cnt_load_c     = 1'b1;
          mem_ce_d       = !new_io_c;
          mem_we_d       = !new_io_c && WR;
          io_sel_d       = new_io_c;
          io_we_d        = new_io_c && WR;
          state_d        = BUSR_ACCESS;
        end
      end

      BUSR_ACCESS: begin
        if (cnt_zero_c) begin
          // Last access cycle: capture read data and drop all strobes.
          if (!req_q.is_write) begin
            data_out_d = req_q.is_io ? IO_RDATA : MEM_RDATA;
          end
          ready_d = 1'b1;
          state_d = BUSR_ACK;
        end else begin
          cnt_dec_c = 1'b1;
          mem_ce_d  = !req_q.is_io;
          mem_we_d  = !req_q.is_io && req_q.is_write;
          io_sel_d  = req_q.is_io;
          io_we_d   = req_q.is_io && req_q.is_write;
        end
      end

      BUSR_ACK: begin
        state_d = BUSR_RELEASE;
      end

      BUSR_RELEASE: begin
        // A still-held request must not start a second access.
        if (!RD && !WR) begin
          state_d = BUSR_IDLE;
        end
      end

      default: begin
        state_d = BUSR_IDLE;
      end
    endcase
  end

  // State, latched request and output registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q    <= BUSR_IDLE;
      req_q      <= '0;
      data_out_q <= '0;
      ready_q    <= 1'b0;
      bus_err_q  <= 1'b0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      io_sel_q   <= 1'b0;
      io_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      data_out_q <= data_out_d;
      ready_q    <= ready_d;
      bus_err_q  <= bus_err_d;
      mem_ce_q   <= mem_ce_d;
      mem_we_q   <= mem_we_d;
      io_sel_q   <= io_sel_d;
      io_we_q    <= io_we_d;
    end
  end

  assign DATA_OUT  = data_out_q;
  assign READY     = ready_q;
  assign BUS_ERR   = bus_err_q;
  assign MEM_ADDR  = req_q.addr;
  assign MEM_WDATA = req_q.wdata;
  assign MEM_CE    = mem_ce_q;
  assign MEM_WE    = mem_we_q;
  assign IO_SEL    = io_sel_q;
  assign IO_WE     = io_we_q;

endmodule

// File: doc/addr_bus_responder.md
Name: addr_bus_responder

Overview:
- Memory-side responder for the CPU address/data bus. It sits downstream of the address bus multiplexer and consumes the selected 16-bit ADDR together with RD/WR request strobes.
- Decodes each access into the RAM region or the IO region, inserts programmable wait states, and drives the SRAM or IO strobes.
- Completes each access with a one-cycle READY pulse and a registered DATA_OUT.
- Uses a four-state handshake FSM that prevents a held request from re-triggering.

Parameters:
- WAIT_STATES, 1, extra access cycles inserted before completion; legal range 0..15.
- IO_BASE, 16'hFF00, lowest IO address; ADDR >= IO_BASE selects IO, otherwise RAM.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RESETN  in  1  asynchronous active-low reset.
- ADDR  in  16  word address from the address bus controller.
- DATA_IN  in  16  write data from the CPU.
- RD  in  1  read request; level, held by the requester until READY is seen.
- WR  in  1  write request; level, held by the requester until READY is seen.
- DATA_OUT  out  16  registered read data.
- READY  out  1  one-cycle completion pulse.
- BUS_ERR  out  1  one-cycle pulse on an illegal request.
- MEM_ADDR  out  16  latched address to SRAM.
- MEM_WDATA  out  16  latched write data to SRAM and IO.
- MEM_RDATA  in  16  SRAM read data, valid while MEM_CE is high.
- MEM_CE  out  1  SRAM chip enable.
- MEM_WE  out  1  SRAM write enable.
- IO_SEL  out  1  IO region select.
- IO_WE  out  1  IO write enable.
- IO_RDATA  in  16  IO read data, valid while IO_SEL is high.

Behaviour:
- Clock and reset: one clock, CLK. Reset is asynchronous and active-low on RESETN.
- Values while RESETN is low:
  - State IDLE, wait counter 0.
  - READY, BUS_ERR, MEM_CE, MEM_WE, IO_SEL, IO_WE all 0.
  - DATA_OUT, MEM_ADDR, MEM_WDATA all 16'h0000.
- Reset asserted mid-access: all strobes drop immediately (asynchronously). No READY is issued for the aborted access.
- IDLE:
  - RD xor WR high at an edge: latch ADDR into MEM_ADDR, DATA_IN into MEM_WDATA, direction, and region (ADDR >= IO_BASE). Load counter with WAIT_STATES and go to ACCESS.
  - RD and WR both high: pulse BUS_ERR for one cycle, go to RELEASE, perform no access.
- ACCESS:
  - RAM region: MEM_CE=1, and MEM_WE=1 for writes.
  - IO region: IO_SEL=1, and IO_WE=1 for writes.
  - All strobes are registered and stable for the whole state.
  - Counter decrements each cycle.
  - At the edge where the counter is 0: on a read, DATA_OUT <= MEM_RDATA or IO_RDATA according to region; go to ACK.
  - ACCESS duration: WAIT_STATES+1 cycles.
- ACK: READY=1 for exactly one cycle, with all strobes low. Next state is RELEASE.
- RELEASE: wait until RD=0 and WR=0, then go to IDLE. A request still held here is ignored, so one request yields one access.
- Latency: READY is high in the cycle after the (WAIT_STATES+2)th rising edge counting the sampling edge. For WAIT_STATES=1 that is 3 edges.
- DATA_OUT holds its value until the next read completes; writes do not change it.
- ADDR, DATA_IN, RD and WR changes during ACCESS are ignored; latched values are used.
- IO boundary: IO_BASE-1 decodes as RAM; IO_BASE decodes as IO; 16'hFFFF decodes as IO.

Decomposition:
- Shared constants file gains:
  - State encodings BUSR_IDLE=2'b00, BUSR_ACCESS=2'b01, BUSR_ACK=2'b10, BUSR_RELEASE=2'b11.
  - The default IO_BASE constant.
- The 4-bit wait counter is the only natural sub-module: busr_wait_counter, with load, decrement and zero flag.
- FSM, region decode and output registers stay in the top module.

Test Plan:
- RAM read, WAIT_STATES=1: ADDR=16'h1234, RD=1, MEM_RDATA=16'hBEEF.
  - Required: MEM_CE high for 2 cycles, READY pulse 3 edges after sampling, DATA_OUT=16'hBEEF, MEM_WE never high.
- IO write: ADDR=16'hFF04, DATA_IN=16'h00A5, WR=1.
  - Required: IO_SEL and IO_WE high for WAIT_STATES+1 cycles, MEM_WDATA=16'h00A5, MEM_CE=0, one READY pulse, DATA_OUT unchanged.
- Boundary decode: reads at 16'hFEFF, 16'hFF00 and 16'hFFFF.
  - Required: first asserts MEM_CE only; second and third assert IO_SEL only.
- Held request: RD held high for 10 cycles after READY, then dropped and re-raised.
  - Required: exactly one access while held, and a second access only after the drop.
- Illegal request: RD=WR=1 in IDLE.
  - Required: BUS_ERR pulses one cycle, no strobes, no READY, return to IDLE only after both are low.
- Reset mid-access: RESETN driven low during ACCESS with WAIT_STATES=3.
  - Required: strobes drop without waiting for a clock edge, DATA_OUT=0, no READY, a new read after release completes normally.
- Repeat the first scenario with WAIT_STATES=0 (READY after 2 edges) and WAIT_STATES=15 (READY after 17 edges).
